// File: rtl/score_pkg.sv
// Shared types and constants for the score playback sequencer:
// FSM state encoding, note-word field layout and the duration helper.
package score_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_PLAY  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int NOTE_W    = 16;
  localparam int WIN_SLOTS = 4;
  localparam int WIN_W     = NOTE_W * WIN_SLOTS;
  localparam int DUR_W     = 8;

  localparam int PITCH_MSB = 15;
  localparam int PITCH_LSB = 8;
  localparam int DUR_MSB   = 7;
  localparam int DUR_LSB   = 0;

  localparam logic [7:0] END_PITCH = 8'hFF;

  // A zero-length note still occupies one beat.
  function automatic logic [DUR_W-1:0] note_dur(input logic [DUR_W-1:0] dur);
    return (dur == '0) ? DUR_W'(1) : dur;
  endfunction

endpackage

// File: rtl/score_window.sv
// Four-slot look-ahead window of note words. Slot 0 is the current note and
// sits in the top 16 bits of window_o. Supports a per-slot load and a
// shift-up that discards slot 0 and clears slot 3.
module score_window
  import score_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              shift_i,
  input  logic              load_i,
  input  logic [1:0]        load_slot_i,
  input  logic [NOTE_W-1:0] load_data_i,
  output logic [WIN_W-1:0]  window_o
);

  logic [NOTE_W-1:0] slot_q [WIN_SLOTS];
  logic [NOTE_W-1:0] slot_d [WIN_SLOTS];

  // Next window contents: shift-up first, then an optional single-slot load.
  always_comb begin
    for (int i = 0; i < WIN_SLOTS; i++) begin
      slot_d[i] = slot_q[i];
    end
    if (shift_i) begin
      for (int i = 0; i < WIN_SLOTS - 1; i++) begin
        slot_d[i] = slot_q[i + 1];
      end
      slot_d[WIN_SLOTS-1] = '0;
    end
    if (load_i) begin
      slot_d[load_slot_i] = load_data_i;
    end
  end

  // Window storage; cleared by reset so the visible window reads zero.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      for (int i = 0; i < WIN_SLOTS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIN_SLOTS; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign window_o = {slot_q[0], slot_q[1], slot_q[2], slot_q[3]};

endmodule

// File: rtl/score_playback_sequencer.sv
// Score playback sequencer: fetches note words of the selected song from a
// synchronous score ROM, keeps a 4-note look-ahead window and advances it on
// tempo beats according to each note's duration.
// Optional build macro LOOP_EN: an end marker restarts the same song with a
// one-cycle song_done pulse instead of stopping in DONE.
// ADDR_W must equal 2 + SONG_LOG2 (two song-select bits above the offset).
module score_playback_sequencer
  import score_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int SONG_LOG2 = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        song_id,
  input  logic              start,
  input  logic              pause,
  input  logic              beat_tick,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0] rom_data,
  output logic [WIN_W-1:0]  next_notes,
  output logic              note_valid,
  output logic [DUR_W-1:0]  beat_in_note,
  output logic              busy,
  output logic              song_done
);

  state_e                 state_q, state_d;
  logic [1:0]             song_q, song_d;
  logic [SONG_LOG2-1:0]   fptr_q, fptr_d;
  logic [2:0]             step_q, step_d;
  logic [ADDR_W-1:0]      rom_addr_q, rom_addr_d;
  logic [DUR_W-1:0]       bin_q, bin_d;
  logic                   pend_q, pend_d;
`ifdef LOOP_EN
  logic                   done_pulse_q, done_pulse_d;
`endif

  logic                   win_shift;
  logic                   win_load;
  logic [1:0]             win_slot;
  logic [WIN_W-1:0]       window;

  logic [NOTE_W-1:0]      cur_note;
  logic                   cur_is_end;
  logic [DUR_W-1:0]       cur_dur;
  logic                   beat_go;
  logic                   note_over;

  assign cur_note   = window[WIN_W-1 -: NOTE_W];
  assign cur_is_end = (cur_note[PITCH_MSB:PITCH_LSB] == END_PITCH);
  assign cur_dur    = note_dur(cur_note[DUR_MSB:DUR_LSB]);
  // A beat counts when one is arriving now or one was held back earlier.
  assign beat_go    = (beat_tick | pend_q) & ~pause;
  // Compare at 9 bits so a 255-beat note cannot wrap the counter.
  assign note_over  = (({1'b0, bin_q} + 9'd1) == {1'b0, cur_dur});

  score_window u_window (
    .clk_i       (clk),
    .reset_ni    (reset),
    .shift_i     (win_shift),
    .load_i      (win_load),
    .load_slot_i (win_slot),
    .load_data_i (rom_data),
    .window_o    (window)
  );

  // Next-state logic for the playback FSM, fetch pointer and beat counter.
  always_comb begin
    state_d    = state_q;
    song_d     = song_q;
    fptr_d     = fptr_q;
    step_d     = step_q;
    rom_addr_d = rom_addr_q;
    bin_d      = bin_q;
    pend_d     = pend_q;
`ifdef LOOP_EN
    done_pulse_d = 1'b0;
`endif
    win_shift  = 1'b0;
    win_load   = 1'b0;
    win_slot   = 2'd0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Word 0 address goes out now; fptr then names the next word to fetch.
        if (start) begin
          song_d     = song_id;
          rom_addr_d = ADDR_W'({song_id, {SONG_LOG2{1'b0}}});
          fptr_d     = SONG_LOG2'(1);
          step_d     = 3'd0;
          bin_d      = '0;
          pend_d     = 1'b0;
          state_d    = ST_FILL;
        end
      end

      ST_FILL: begin
        if (beat_tick) begin
          pend_d = 1'b1;
        end
        // Addresses 1..3 go out on steps 0..2; data for word k lands on step k+1.
        if (step_q < 3'd3) begin
          rom_addr_d = ADDR_W'({song_q, fptr_q});
          fptr_d     = fptr_q + 1'b1;
        end
        if (step_q != 3'd0) begin
          win_load = 1'b1;
          win_slot = 2'(step_q - 3'd1);
        end
        if (step_q == 3'd4) begin
          step_d  = 3'd0;
          state_d = ST_PLAY;
        end else begin
          step_d = step_q + 3'd1;
        end
      end

      ST_PLAY: begin
        if (cur_is_end) begin
          pend_d = 1'b0;
`ifdef LOOP_EN
          rom_addr_d   = ADDR_W'({song_q, {SONG_LOG2{1'b0}}});
          fptr_d       = SONG_LOG2'(1);
          step_d       = 3'd0;
          bin_d        = '0;
          done_pulse_d = 1'b1;
          state_d      = ST_FILL;
`else
          state_d = ST_DONE;
`endif
        end else begin
          if (beat_tick && pause) begin
            pend_d = 1'b1;
          end
          if (beat_go) begin
            pend_d = 1'b0;
            if (note_over) begin
              win_shift  = 1'b1;
              rom_addr_d = ADDR_W'({song_q, fptr_q});
              step_d     = 3'd0;
              state_d    = ST_SHIFT;
            end else begin
              bin_d = bin_q + 1'b1;
            end
          end
        end
      end

      ST_SHIFT: begin
        if (beat_tick) begin
          pend_d = 1'b1;
        end
        // First cycle waits for the ROM; second cycle captures its word into slot 3.
        if (step_q == 3'd0) begin
          step_d = 3'd1;
        end else begin
          win_load = 1'b1;
          win_slot = 2'd3;
          fptr_d   = fptr_q + 1'b1;
          bin_d    = '0;
          step_d   = 3'd0;
          state_d  = ST_PLAY;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and address registers; reset returns everything to IDLE with zeros.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      song_q     <= '0;
      fptr_q     <= '0;
      step_q     <= '0;
      rom_addr_q <= '0;
      bin_q      <= '0;
      pend_q     <= 1'b0;
`ifdef LOOP_EN
      done_pulse_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      song_q     <= song_d;
      fptr_q     <= fptr_d;
      step_q     <= step_d;
      rom_addr_q <= rom_addr_d;
      bin_q      <= bin_d;
      pend_q     <= pend_d;
`ifdef LOOP_EN
      done_pulse_q <= done_pulse_d;
`endif
    end
  end

  assign rom_addr     = rom_addr_q;
  assign next_notes   = window;
  assign beat_in_note = bin_q;
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign note_valid   = ((state_q == ST_PLAY) || (state_q == ST_SHIFT)) && !cur_is_end;
`ifdef LOOP_EN
  assign song_done    = done_pulse_q;
`else
  assign song_done    = (state_q == ST_DONE);
`endif

endmodule
